// File: rtl/ps2_ctrl.sv
// rtl/ps2_ctrl.sv - PS/2 line controller: frame receive, byte history, host command transmit
//
// Purpose:
//   Receives device-to-host PS/2 frames into a 24-bit byte history for the
//   scan-code translator and transmits host commands (LED set, reset, ...)
//   over the same open-drain bus. A command is checked for the device ACK
//   and its 0xFA / 0xFE reply, and is resent a bounded number of times.
//   Optional build macro: PS2_CTRL_BAT_WAIT_EN. When it is defined, command
//   0xFF waits after 0xFA for the self-test result (0xAA done, 0xFC error).
//
// Ports:
//   i_clk, i_rst_n        system clock, synchronous active-low reset
//   i_ps2_clk, i_ps2_dat  raw PS/2 pins (asynchronous)
//   o_ps2_clk_oe          1 = pull PS/2 clock low
//   o_ps2_dat_oe          1 = pull PS/2 data low
//   i_cmd_valid, i_cmd_data, o_cmd_ready   command handshake
//   o_cmd_done, o_cmd_err 1-cycle command result pulses
//   o_ps2_data            received byte history, newest byte in [7:0]
//   o_rx_valid, o_rx_err  1-cycle receive result pulses
module ps2_ctrl #(
   parameter int INHIBIT_CYC = 2500,
   parameter int TIMEOUT_CYC = 50000,
   parameter int MAX_RETRY   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ps2_clk,
   input  logic        i_ps2_dat,
   output logic        o_ps2_clk_oe,
   output logic        o_ps2_dat_oe,
   input  logic        i_cmd_valid,
   input  logic [7:0]  i_cmd_data,
   output logic        o_cmd_ready,
   output logic        o_cmd_done,
   output logic        o_cmd_err,
   output logic [23:0] o_ps2_data,
   output logic        o_rx_valid,
   output logic        o_rx_err
);

   localparam int TMR_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      IDLE, RX, INHIBIT, REQ, TX_BITS, TX_ACK, WAIT_RESP
   } state_t;

   state_t        state_q, state_d;
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic [2:0]    clk_hist_q;
   logic          clk_f_q;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    rx_sh_q, rx_sh_d;
   logic [10:0]   tx_sh_q, tx_sh_d;
   logic [7:0]    cmd_byte_q, cmd_byte_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [23:0]   hist_q, hist_d;
   logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
   logic          cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;
`ifdef PS2_CTRL_BAT_WAIT_EN
   logic          bat_q, bat_d;
`endif

   logic          clk_maj, fall, timeout, rx_shift, frame_end, frame_ok;
   logic [10:0]   frame_sh;
   logic [7:0]    frame_byte;

   // Host frame as shifted out LSB first: start 0, data, odd parity, stop 1.
   function automatic logic [10:0] tx_frame(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   assign clk_maj  = (clk_hist_q[0] & clk_hist_q[1]) | (clk_hist_q[1] & clk_hist_q[2]) |
                     (clk_hist_q[0] & clk_hist_q[2]);
   assign fall     = clk_f_q & ~clk_maj;
   assign timeout  = (tmr_q >= TW'(TIMEOUT_CYC));

   // The bit receiver also collects command replies while in WAIT_RESP.
   assign rx_shift   = fall & ((state_q == IDLE) || (state_q == RX) || (state_q == WAIT_RESP));
   assign frame_sh   = {dat_s2_q, rx_sh_q};
   assign frame_end  = rx_shift & (bit_cnt_q == 4'd10);
   assign frame_ok   = ~frame_sh[0] & frame_sh[10] & (^frame_sh[9:1]);
   assign frame_byte = frame_sh[8:1];

   assign o_ps2_clk_oe = (state_q == INHIBIT);
   assign o_ps2_dat_oe = ((state_q == REQ) || (state_q == TX_BITS)) & ~tx_sh_q[0];
   // A device fall in the same cycle takes the bus, so the command waits.
   assign o_cmd_ready  = i_rst_n & (state_q == IDLE) & (bit_cnt_q == 4'd0) & ~fall;
   assign o_cmd_done   = cmd_done_q;
   assign o_cmd_err    = cmd_err_q;
   assign o_ps2_data   = hist_q;
   assign o_rx_valid   = rx_valid_q;
   assign o_rx_err     = rx_err_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sh_d    = rx_sh_q;
      tx_sh_d    = tx_sh_q;
      cmd_byte_d = cmd_byte_q;
      retry_d    = retry_q;
      hist_d     = hist_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      cmd_done_d = 1'b0;
      cmd_err_d  = 1'b0;
`ifdef PS2_CTRL_BAT_WAIT_EN
      bat_d      = bat_q;
`endif
      // Saturating gap timer; restarts on every device fall. In INHIBIT it
      // measures the hold time, and the fall caused by our own pull is ignored.
      tmr_d = (tmr_q == TW'(TMR_MAX)) ? tmr_q : tmr_q + TW'(1);
      if (fall && (state_q != INHIBIT)) begin
         tmr_d = '0;
      end

      if (rx_shift) begin
         rx_sh_d   = frame_sh[10:1];
         bit_cnt_d = frame_end ? 4'd0 : bit_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = RX;
            end else if (i_cmd_valid && o_cmd_ready) begin
               state_d    = INHIBIT;
               tx_sh_d    = tx_frame(i_cmd_data);
               cmd_byte_d = i_cmd_data;
               retry_d    = '0;
               tmr_d      = '0;
`ifdef PS2_CTRL_BAT_WAIT_EN
               bat_d      = 1'b0;
`endif
            end
         end
         RX: begin
            if (frame_end) begin
               state_d = IDLE;
               if (frame_ok) begin
                  hist_d     = {hist_q[15:0], frame_byte};
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
            end else if (!fall && timeout) begin
               state_d   = IDLE;
               rx_err_d  = 1'b1;
               bit_cnt_d = 4'd0;
            end
         end
         INHIBIT: begin
            if (tmr_q >= TW'(INHIBIT_CYC - 1)) begin
               state_d = REQ;
               tmr_d   = '0;
            end
         end
         REQ: begin
            state_d   = TX_BITS;
            bit_cnt_d = 4'd0;
            tmr_d     = '0;
         end
         TX_BITS: begin
            // Falls 1..9 present data bits then parity; fall 10 presents the stop.
            if (fall) begin
               tx_sh_d   = {1'b1, tx_sh_q[10:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  state_d   = TX_ACK;
                  bit_cnt_d = 4'd0;
               end
            end else if (timeout) begin
               state_d   = IDLE;
               cmd_err_d = 1'b1;
               bit_cnt_d = 4'd0;
            end
         end
         TX_ACK: begin
            if (fall) begin
               if (!dat_s2_q) begin
                  state_d = WAIT_RESP;
               end else begin
                  state_d   = IDLE;
                  cmd_err_d = 1'b1;
               end
            end else if (timeout) begin
               state_d   = IDLE;
               cmd_err_d = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (frame_end) begin
               state_d = IDLE;
               if (!frame_ok) begin
                  cmd_err_d = 1'b1;
`ifdef PS2_CTRL_BAT_WAIT_EN
               end else if (bat_q) begin
                  if (frame_byte == 8'hAA) cmd_done_d = 1'b1;
                  else                     cmd_err_d  = 1'b1;
               end else if ((frame_byte == 8'hFA) && (cmd_byte_q == 8'hFF)) begin
                  bat_d   = 1'b1;
                  state_d = WAIT_RESP;
`endif
               end else if (frame_byte == 8'hFA) begin
                  cmd_done_d = 1'b1;
               end else if ((frame_byte == 8'hFE) && ((retry_q + RW'(1)) <= RW'(MAX_RETRY))) begin
                  retry_d = retry_q + RW'(1);
                  state_d = INHIBIT;
                  tx_sh_d = tx_frame(cmd_byte_q);
                  tmr_d   = '0;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end else if (!fall && timeout) begin
               state_d   = IDLE;
               cmd_err_d = 1'b1;
               bit_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_hist_q <= 3'b111;
         clk_f_q    <= 1'b1;
         bit_cnt_q  <= 4'd0;
         rx_sh_q    <= '0;
         tx_sh_q    <= '1;
         cmd_byte_q <= '0;
         retry_q    <= '0;
         tmr_q      <= '0;
         hist_q     <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         cmd_done_q <= 1'b0;
         cmd_err_q  <= 1'b0;
`ifdef PS2_CTRL_BAT_WAIT_EN
         bat_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         clk_s1_q   <= i_ps2_clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= i_ps2_dat;
         dat_s2_q   <= dat_s1_q;
         clk_hist_q <= {clk_hist_q[1:0], clk_s2_q};
         clk_f_q    <= clk_maj;
         bit_cnt_q  <= bit_cnt_d;
         rx_sh_q    <= rx_sh_d;
         tx_sh_q    <= tx_sh_d;
         cmd_byte_q <= cmd_byte_d;
         retry_q    <= retry_d;
         tmr_q      <= tmr_d;
         hist_q     <= hist_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         cmd_done_q <= cmd_done_d;
         cmd_err_q  <= cmd_err_d;
`ifdef PS2_CTRL_BAT_WAIT_EN
         bat_q      <= bat_d;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_ctrl.sv
// tb/tb_ps2_ctrl.sv - directed self-checking bench for ps2_ctrl
module tb_ps2_ctrl;

   localparam int INH = 100;
   localparam int TMO = 300;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        dev_clk = 1'b1;
   logic        dev_dat = 1'b1;
   logic        bus_clk, bus_dat;
   logic        o_ps2_clk_oe, o_ps2_dat_oe;
   logic        i_cmd_valid = 1'b0;
   logic [7:0]  i_cmd_data = 8'h00;
   logic        o_cmd_ready, o_cmd_done, o_cmd_err;
   logic [23:0] o_ps2_data;
   logic        o_rx_valid, o_rx_err;

   int n_checks = 0;
   int n_fail   = 0;
   int rxv_cnt  = 0;
   int rxe_cnt  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   // Open-drain bus: either side can pull a line low.
   assign bus_clk = dev_clk & ~o_ps2_clk_oe;
   assign bus_dat = dev_dat & ~o_ps2_dat_oe;

   always #5 i_clk = ~i_clk;

   ps2_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(2)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_ps2_clk    (bus_clk),
      .i_ps2_dat    (bus_dat),
      .o_ps2_clk_oe (o_ps2_clk_oe),
      .o_ps2_dat_oe (o_ps2_dat_oe),
      .i_cmd_valid  (i_cmd_valid),
      .i_cmd_data   (i_cmd_data),
      .o_cmd_ready  (o_cmd_ready),
      .o_cmd_done   (o_cmd_done),
      .o_cmd_err    (o_cmd_err),
      .o_ps2_data   (o_ps2_data),
      .o_rx_valid   (o_rx_valid),
      .o_rx_err     (o_rx_err)
   );

   always @(negedge i_clk) begin
      if (o_rx_valid) rxv_cnt  <= rxv_cnt + 1;
      if (o_rx_err)   rxe_cnt  <= rxe_cnt + 1;
      if (o_cmd_done) done_cnt <= done_cnt + 1;
      if (o_cmd_err)  err_cnt  <= err_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Device-to-host frame; nbits < 11 sends a truncated frame.
   task automatic dev_send(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat = bits[i];
         repeat (10) @(negedge i_clk);
         dev_clk = 1'b0;
         repeat (20) @(negedge i_clk);
         dev_clk = 1'b1;
         repeat (10) @(negedge i_clk);
      end
      dev_dat = 1'b1;
      repeat (20) @(negedge i_clk);
   endtask

   // Device side of a host command: measure inhibit, clock in 10 bits, ACK.
   task automatic host_rx(input logic ack_bit, output logic [7:0] b, output logic p,
                          output logic s, output int inh);
      int n;
      logic [9:0] bits;
      @(negedge i_clk);
      n = 0;
      while (!o_ps2_clk_oe && n < 1000) begin
         @(negedge i_clk);
         n++;
      end
      check_eq("inhibit_seen", o_ps2_clk_oe, 1'b1);
      inh = 0;
      while (o_ps2_clk_oe && inh < 1000) begin
         @(negedge i_clk);
         inh++;
      end
      check_eq("inhibit_released", o_ps2_clk_oe, 1'b0);
      repeat (10) @(negedge i_clk);
      check_eq("tx_start_bit", bus_dat, 1'b0);
      for (int i = 0; i < 10; i++) begin
         repeat (10) @(negedge i_clk);
         dev_clk = 1'b0;
         repeat (20) @(negedge i_clk);
         bits[i] = bus_dat;
         dev_clk = 1'b1;
      end
      b = bits[7:0];
      p = bits[8];
      s = bits[9];
      repeat (10) @(negedge i_clk);
      dev_dat = ack_bit;
      repeat (10) @(negedge i_clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge i_clk);
      dev_clk = 1'b1;
      repeat (10) @(negedge i_clk);
      dev_dat = 1'b1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      int n;
      @(negedge i_clk);
      i_cmd_valid = 1'b1;
      i_cmd_data  = b;
      n = 0;
      while (!o_cmd_ready && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      check_eq("cmd_ready", o_cmd_ready, 1'b1);
      @(posedge i_clk);
      #1 i_cmd_valid = 1'b0;
   endtask

   task automatic no_more_tx(input string tag);
      int n;
      n = 0;
      repeat (200) begin
         @(negedge i_clk);
         if (o_ps2_clk_oe) n++;
      end
      check_eq(tag, n, 0);
   endtask

   initial begin
      logic [7:0] b;
      logic       p, s;
      int         inh, base_d, base_e, base_v, n2;

      // Reset state
      repeat (3) @(negedge i_clk);
      check_eq("rst_data", o_ps2_data, 24'h0);
      check_eq("rst_flags", {o_rx_valid, o_rx_err, o_cmd_done, o_cmd_err}, 4'b0);
      check_eq("rst_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
      check_eq("rst_ready", o_cmd_ready, 1'b0);
      i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);
      check_eq("idle_ready", o_cmd_ready, 1'b1);

      // Received frames build the history
      dev_send(8'h1C, 1'b0, 11);
      check_eq("rx1_valid_cnt", rxv_cnt, 1);
      check_eq("rx1_data", o_ps2_data, 24'h00001C);
      dev_send(8'hF0, 1'b0, 11);
      dev_send(8'h1C, 1'b0, 11);
      check_eq("rx3_valid_cnt", rxv_cnt, 3);
      check_eq("rx3_data", o_ps2_data, 24'h1CF01C);

      // Parity error drops the frame
      dev_send(8'h1C, 1'b1, 11);
      check_eq("par_err_cnt", rxe_cnt, 1);
      check_eq("par_valid_cnt", rxv_cnt, 3);
      check_eq("par_data", o_ps2_data, 24'h1CF01C);

      // Truncated frame times out, next frame still decodes
      dev_send(8'h00, 1'b0, 5);
      repeat (TMO + 50) @(negedge i_clk);
      check_eq("tmo_err_cnt", rxe_cnt, 2);
      check_eq("tmo_ready", o_cmd_ready, 1'b1);
      dev_send(8'h29, 1'b0, 11);
      check_eq("tmo_next_data", o_ps2_data, 24'hF01C29);

      // Command 0xED acknowledged with 0xFA
      base_d = done_cnt; base_e = err_cnt; base_v = rxv_cnt;
      send_cmd(8'hED);
      host_rx(1'b0, b, p, s, inh);
      check_eq("ed_inhibit_len", inh, INH);
      check_eq("ed_byte", b, 8'hED);
      check_eq("ed_parity", p, 1'b1);
      check_eq("ed_stop", s, 1'b1);
      dev_send(8'hFA, 1'b0, 11);
      check_eq("ed_done", done_cnt, base_d + 1);
      check_eq("ed_err", err_cnt, base_e);
      check_eq("ed_hist", o_ps2_data, 24'hF01C29);
      check_eq("ed_no_rxv", rxv_cnt, base_v);

      // Three 0xFE replies exhaust the retries
      base_d = done_cnt; base_e = err_cnt;
      send_cmd(8'hED);
      for (int i = 0; i < 3; i++) begin
         host_rx(1'b0, b, p, s, inh);
         check_eq("retry_byte", b, 8'hED);
         dev_send(8'hFE, 1'b0, 11);
      end
      check_eq("retry_err", err_cnt, base_e + 1);
      check_eq("retry_no_done", done_cnt, base_d);
      no_more_tx("retry_no_4th_tx");

      // 0xFE then 0xFA: one resend, then done
      base_d = done_cnt; base_e = err_cnt;
      send_cmd(8'hED);
      host_rx(1'b0, b, p, s, inh);
      dev_send(8'hFE, 1'b0, 11);
      host_rx(1'b0, b, p, s, inh);
      check_eq("resend_byte", b, 8'hED);
      dev_send(8'hFA, 1'b0, 11);
      check_eq("resend_done", done_cnt, base_d + 1);
      check_eq("resend_err", err_cnt, base_e);
      no_more_tx("resend_no_3rd_tx");

      // Missing ACK fails the command
      base_e = err_cnt;
      send_cmd(8'hF4);
      host_rx(1'b1, b, p, s, inh);
      check_eq("nack_byte", b, 8'hF4);
      repeat (20) @(negedge i_clk);
      check_eq("nack_err", err_cnt, base_e + 1);

      // Command request collides with a device start bit
      base_d = done_cnt; base_v = rxv_cnt;
      fork
         dev_send(8'h1C, 1'b0, 11);
         begin
            n2 = 0;
            while (o_cmd_ready && n2 < 2000) begin
               @(negedge i_clk);
               n2++;
            end
            i_cmd_valid = 1'b1;
            i_cmd_data  = 8'hED;
            @(negedge i_clk);
            check_eq("coll_ready_low", o_cmd_ready, 1'b0);
            check_eq("coll_no_inhibit", o_ps2_clk_oe, 1'b0);
            n2 = 0;
            while (!o_cmd_ready && n2 < 2000) begin
               @(negedge i_clk);
               n2++;
            end
            check_eq("coll_ready_back", o_cmd_ready, 1'b1);
            @(posedge i_clk);
            #1 i_cmd_valid = 1'b0;
            check_eq("coll_frame_first", rxv_cnt, base_v + 1);
         end
      join
      check_eq("coll_hist", o_ps2_data, 24'h1C291C);
      host_rx(1'b0, b, p, s, inh);
      check_eq("coll_byte", b, 8'hED);
      dev_send(8'hFA, 1'b0, 11);
      check_eq("coll_done", done_cnt, base_d + 1);

      // Reset command 0xFF followed by the self-test byte 0xAA
      base_d = done_cnt;
      send_cmd(8'hFF);
      host_rx(1'b0, b, p, s, inh);
      check_eq("ff_byte", b, 8'hFF);
      check_eq("ff_parity", p, 1'b1);
      dev_send(8'hFA, 1'b0, 11);
`ifdef PS2_CTRL_BAT_WAIT_EN
      check_eq("ff_wait_bat", done_cnt, base_d);
      dev_send(8'hAA, 1'b0, 11);
      check_eq("ff_bat_done", done_cnt, base_d + 1);
      check_eq("ff_bat_hist", o_ps2_data, 24'h1C291C);
`else
      check_eq("ff_done", done_cnt, base_d + 1);
      dev_send(8'hAA, 1'b0, 11);
      check_eq("ff_aa_hist", o_ps2_data, 24'h291CAA);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_ctrl.md
Name: ps2_ctrl

Overview:
- PS/2 line controller feeding the scan-code-to-ASCII translator: bit-level receive, 24-bit byte history, host-to-device command transmit.
- Shares the bidirectional PS/2 bus between device-to-host frames and host commands (LED set, reset) with retry on resend.
- Sits between the board PS/2 pins and the keyboard translator; o_ps2_data drives the translator's 24-bit history input.

Parameters:
- INHIBIT_CYC, 2500, cycles clock line is held low before a host request (>=100 us).
- TIMEOUT_CYC, 50000, max cycles between PS/2 clock falling edges inside a frame or response wait.
- MAX_RETRY, 2, resends allowed after a 0xFE reply before failing.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_ps2_clk  in  1  raw PS/2 clock pin
- i_ps2_dat  in  1  raw PS/2 data pin
- o_ps2_clk_oe  out  1  1 = pull PS/2 clock low
- o_ps2_dat_oe  out  1  1 = pull PS/2 data low
- i_cmd_valid  in  1  command request
- i_cmd_data  in  8  command byte
- o_cmd_ready  out  1  command accepted when valid&ready
- o_cmd_done  out  1  1-cycle pulse, command acknowledged (0xFA)
- o_cmd_err  out  1  1-cycle pulse, command failed
- o_ps2_data  out  24  received byte history, newest in [7:0]
- o_rx_valid  out  1  1-cycle pulse, new byte shifted in
- o_rx_err  out  1  1-cycle pulse, bad frame dropped

Behaviour:
- Reset: every output 0, history 0, lines released, FSM IDLE. Reset mid-frame/mid-command aborts without done/err pulse.
- Inputs: 2-FF synchronizer, then 3-sample majority filter on clock; "fall" = filtered clock 1->0.
- RX frame: 11 bits sampled on fall: start 0, 8 data LSB first, odd parity, stop 1. Good frame: cycle after stop fall, o_ps2_data <= {o_ps2_data[15:0], byte}, o_rx_valid=1. Parity/start/stop error: o_rx_err=1, history unchanged. Partial frame with no fall for TIMEOUT_CYC: o_rx_err=1, bit counter cleared.
- FSM: IDLE, RX, INHIBIT, REQ, TX_BITS, TX_ACK, WAIT_RESP.
- IDLE: o_cmd_ready=1 only in IDLE with RX bit counter 0. Device fall and i_cmd_valid in same cycle: RX wins, ready=0, command stays pending.
- Accept -> INHIBIT: clk_oe=1 for INHIBIT_CYC; byte and odd parity latched.
- REQ: dat_oe=1, clk_oe=0 (start bit), go TX_BITS.
- TX_BITS: on each fall present next bit (data LSB first, then parity); dat_oe = ~bit. After parity bit's fall, release data (stop).
- TX_ACK: next fall with filtered data 0 -> WAIT_RESP; data 1 -> o_cmd_err, IDLE.
- WAIT_RESP: RX path receives reply; reply bytes never enter history, no o_rx_valid. 0xFA -> o_cmd_done, IDLE. 0xFE -> retry counter +1, back to INHIBIT if counter <= MAX_RETRY else o_cmd_err. Other byte, bad frame, or TIMEOUT_CYC without fall -> o_cmd_err, IDLE.
- Any TX state exceeding TIMEOUT_CYC between falls -> release lines, o_cmd_err, IDLE.
- Retry counter clears on accept. Timeout counters saturate; no wrap.
- clk_oe and dat_oe both 0 in IDLE and RX.

Optional Feature:
- PS2_CTRL_BAT_WAIT_EN: when defined and command byte is 0xFF, after 0xFA FSM stays in WAIT_RESP for BAT: 0xAA -> o_cmd_done; 0xFC or timeout -> o_cmd_err. Undefined: 0xFF completes on 0xFA like any command; later 0xAA enters history as a normal byte.

Test Plan:
- From reset, device sends 0x1C (parity 0) -> one o_rx_valid pulse, o_ps2_data=0x00001C; then 0xF0, 0x1C -> o_ps2_data=0x1CF01C.
- Frame 0x1C with parity 1 -> o_rx_err pulse, o_ps2_data unchanged, no o_rx_valid.
- Send start + 4 bits then stop clocking -> o_rx_err after TIMEOUT_CYC; next full frame 0x29 -> history [7:0]=0x29.
- Command 0xED: clock held low INHIBIT_CYC, bits 1,0,1,1,0,1,1,1, parity 1; device ACKs and replies 0xFA -> o_cmd_done, history unchanged.
- Command 0xED, device replies 0xFE, 0xFE, 0xFE (MAX_RETRY=2) -> three transmissions, o_cmd_err after third 0xFE; with 0xFE then 0xFA -> two transmissions, o_cmd_done.
- i_cmd_valid asserted same cycle as device start-bit fall -> o_cmd_ready=0; frame received, then command accepted in IDLE.
